// File: rtl/data_mem_ctrl.sv
// Handshaked byte/half/word data memory with configurable access latency.
// Reports misaligned, out-of-range and illegal-op accesses instead of executing them.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_op,
    input  logic        req_ext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);
    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int unsigned OW    = DEPTH_LOG2 + 2;
    localparam logic [1:0] MEM_BYTE  = 2'b00;
    localparam logic [1:0] MEM_HALF  = 2'b01;
    localparam logic [1:0] MEM_WORD  = 2'b10;
    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_OP    = 2'b11;
    localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES == 32'd0) ? 3'd0 : 3'(WAIT_CYCLES - 32'd1);

    typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10} state_t;

    state_t        state_r;
    logic [2:0]    count_r;
    logic          we_r;
    logic [1:0]    op_r;
    logic          ext_r;
    logic [OW-1:0] offset_r;
    logic [31:0]   wdata_r;
    logic [31:0]   mem_r [0:DEPTH-1];

    logic [31:0]         req_off_s;
    logic [1:0]          req_err_s;
    logic                accept_s;
    logic                acc_we_s;
    logic [1:0]          acc_op_s;
    logic                acc_ext_s;
    logic [OW-1:0]       acc_off_s;
    logic [31:0]         acc_wdata_s;
    logic [DEPTH_LOG2-1:0] acc_idx_s;
    logic [31:0]         rd_word_s;
    logic [31:0]         load_s;
    logic [31:0]         merged_s;
    logic                do_access_s;

    function automatic logic [1:0] check_err(input logic [1:0] op, input logic [31:0] off);
        if ((op != MEM_BYTE) && (op != MEM_HALF) && (op != MEM_WORD)) begin
            return ERR_OP;
        end else if ((off >> OW) != 32'd0) begin
            return ERR_RANGE;
        end else if (((op == MEM_HALF) && off[0]) || ((op == MEM_WORD) && (off[1:0] != 2'b00))) begin
            return ERR_ALIGN;
        end else begin
            return ERR_OK;
        end
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] op,
                                                 input logic [1:0] lane, input logic ext);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (op)
            MEM_BYTE: return ext ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
            MEM_HALF: return ext ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
            MEM_WORD: return word;
            default:  return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                                input logic [1:0] op, input logic [1:0] lane);
        logic [31:0] mask;
        case (op)
            MEM_BYTE: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                return (old & ~mask) | ({4{wdata[7:0]}} & mask);
            end
            MEM_HALF: begin
                mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                return (old & ~mask) | ({2{wdata[15:0]}} & mask);
            end
            MEM_WORD: return wdata;
            default:  return old;
        endcase
    endfunction

    assign req_ready = (state_r == IDLE) && !rst;

    // Access operands come straight from the request on a zero-wait accept, else from the latches.
    always_comb begin
        req_off_s = req_addr - BASE_ADDR;
        req_err_s = check_err(req_op, req_off_s);
        accept_s  = req_valid && req_ready;
        if (state_r == ACCESS) begin
            acc_we_s    = we_r;
            acc_op_s    = op_r;
            acc_ext_s   = ext_r;
            acc_off_s   = offset_r;
            acc_wdata_s = wdata_r;
            do_access_s = (count_r == 3'd0);
        end else begin
            acc_we_s    = req_we;
            acc_op_s    = req_op;
            acc_ext_s   = req_ext;
            acc_off_s   = req_off_s[OW-1:0];
            acc_wdata_s = req_wdata;
            do_access_s = accept_s && (req_err_s == ERR_OK) && (WAIT_CYCLES == 32'd0);
        end
        acc_idx_s = acc_off_s[OW-1:2];
        rd_word_s = mem_r[acc_idx_s];
        load_s    = load_extract(rd_word_s, acc_op_s, acc_off_s[1:0], acc_ext_s);
        merged_s  = store_merge(rd_word_s, acc_wdata_s, acc_op_s, acc_off_s[1:0]);
    end

    // Storage array: no reset, and a commit coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && do_access_s && acc_we_s) begin
            mem_r[acc_idx_s] <= merged_s;
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            count_r   <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= ERR_OK;
            we_r      <= 1'b0;
            op_r      <= MEM_BYTE;
            ext_r     <= 1'b0;
            offset_r  <= '0;
            wdata_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        we_r     <= req_we;
                        op_r     <= req_op;
                        ext_r    <= req_ext;
                        offset_r <= req_off_s[OW-1:0];
                        wdata_r  <= req_wdata;
                        if (req_err_s != ERR_OK) begin
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err_s;
                            rsp_rdata <= 32'h0000_0000;
                        end else if (WAIT_CYCLES == 32'd0) begin
                            state_r   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= ERR_OK;
                            rsp_rdata <= req_we ? 32'h0000_0000 : load_s;
                        end else begin
                            state_r <= ACCESS;
                            count_r <= WAIT_INIT;
                        end
                    end
                end
                ACCESS: begin
                    if (count_r == 3'd0) begin
                        state_r   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_OK;
                        rsp_rdata <= we_r ? 32'h0000_0000 : load_s;
                    end else begin
                        count_r <= count_r - 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r   <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0000_0000;
                        rsp_err   <= ERR_OK;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (WAIT_CYCLES 1, 0, 7) checked against
// an arithmetic reference model with directed and random requests.
module tb_data_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we [3];
    logic [1:0]  req_op [3];
    logic        req_ext [3];
    logic [31:0] req_addr [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic [1:0]  rsp_err [3];

    logic [31:0] mdl [3][1024];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_ctrl #(
            .DEPTH_LOG2(10),
            .BASE_ADDR(32'h0000_1000),
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 7))
        ) dut (
            .clk(clk), .rst(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_we(req_we[g]), .req_op(req_op[g]), .req_ext(req_ext[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
        );
    end

    function automatic int wc_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 7);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mdl_err(input logic [1:0] op, input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'h0000_1000;
        if (op == 2'd3) return 2'd3;
        if (off >= 32'd4096) return 2'd2;
        if (op == 2'd1 && (off % 32'd2) != 32'd0) return 2'd1;
        if (op == 2'd2 && (off % 32'd4) != 32'd0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] op,
                                             input int lane, input logic ext);
        logic [31:0] v;
        if (op == 2'd0) begin
            v = (w >> (8 * lane)) % 32'd256;
            if (ext && v >= 32'd128) v = v - 32'd256;
        end else if (op == 2'd1) begin
            v = (w >> (8 * lane)) % 32'd65536;
            if (ext && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] mdl_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] op, input int lane);
        logic [31:0] unit, mask;
        if (op == 2'd2) return d;
        unit = (op == 2'd0) ? 32'd256 : 32'd65536;
        mask = (unit - 32'd1) << (8 * lane);
        return (w & ~mask) | (((d % unit) << (8 * lane)) & mask);
    endfunction

    task automatic xact(input int k, input logic we, input logic [1:0] op, input logic ext,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic [1:0] er);
        logic [1:0]  exp_err;
        logic [31:0] exp_rd, off;
        int lat, idx, lane;
        exp_err = mdl_err(op, addr);
        off  = addr - 32'h0000_1000;
        idx  = int'(off / 32'd4);
        lane = int'(off % 32'd4);
        exp_rd = 32'd0;
        if (exp_err == 2'd0 && !we) exp_rd = mdl_load(mdl[k][idx], op, lane, ext);
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_op[k] = op; req_ext[k] = ext;
        req_addr[k] = addr; req_wdata[k] = wdata;
        #1 check("req_ready_idle", 32'(req_ready[k]), 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 0;
        while (!rsp_valid[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), (exp_err != 2'd0) ? 32'd0 : 32'(wc_of(k)));
        check("rsp_rdata", rsp_rdata[k], exp_rd);
        check("rsp_err", 32'(rsp_err[k]), 32'(exp_err));
        rd = rsp_rdata[k];
        er = rsp_err[k];
        if (exp_err == 2'd0 && we) mdl[k][idx] = mdl_store(mdl[k][idx], wdata, op, lane);
        @(posedge clk); #1;
        check("rsp_consumed", 32'(rsp_valid[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, held;
        logic [1:0]  er;
        int lat;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0; req_op[k] = 2'd0;
            req_ext[k] = 1'b0; req_addr[k] = 32'd0; req_wdata[k] = 32'd0; rsp_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_valid", 32'(rsp_valid[k]), 32'd0);
            check("reset_rdata", rsp_rdata[k], 32'd0);
            check("reset_err", 32'(rsp_err[k]), 32'd0);
            check("reset_ready_low", 32'(req_ready[k]), 32'd0);
            rst[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 3; k++) check("ready_after_reset", 32'(req_ready[k]), 32'd1);

        // Word round trip (WAIT_CYCLES = 1)
        xact(0, 1'b1, 2'd2, 1'b0, 32'h1008, 32'hDEAD_BEEF, rd, er);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, rd, er);
        check("roundtrip_word", rd, 32'hDEAD_BEEF);

        // Byte merge and extension
        xact(0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h1122_3344, rd, er);
        xact(0, 1'b1, 2'd0, 1'b0, 32'h1002, 32'h0000_0080, rd, er);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, rd, er);
        check("merge_word", rd, 32'h1180_3344);
        xact(0, 1'b0, 2'd0, 1'b1, 32'h1002, 32'h0, rd, er);
        check("load_byte_sext", rd, 32'hFFFF_FF80);
        xact(0, 1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, rd, er);
        check("load_half_zext", rd, 32'h0000_1180);

        // Error cases leave memory untouched
        xact(0, 1'b1, 2'd2, 1'b0, 32'h1004, 32'h5555_AAAA, rd, er);
        xact(0, 1'b0, 2'd1, 1'b0, 32'h1001, 32'h0, rd, er);
        check("err_misaligned", 32'(er), 32'd1);
        xact(0, 1'b1, 2'd2, 1'b0, 32'h2000, 32'hFFFF_FFFF, rd, er);
        check("err_range", 32'(er), 32'd2);
        xact(0, 1'b1, 2'd3, 1'b0, 32'h1004, 32'hFFFF_FFFF, rd, er);
        check("err_op", 32'(er), 32'd3);
        check("err_op_rdata", rd, 32'd0);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, rd, er);
        check("err_mem_intact", rd, 32'h5555_AAAA);

        // Backpressure: stalled response must hold and block new requests
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_op[0] = 2'd2; req_addr[0] = 32'h1008;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        lat = 0;
        while (!rsp_valid[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        held = rsp_rdata[0];
        check("bp_data", held, 32'hDEAD_BEEF);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wdata[0] = 32'h0BAD_F00D;
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(rsp_valid[0]), 32'd1);
            check("bp_rdata_stable", rsp_rdata[0], held);
            check("bp_ready_low", 32'(req_ready[0]), 32'd0);
        end
        @(negedge clk);
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_released", 32'(rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        check("bp_single_rsp", 32'(rsp_valid[0]), 32'd0);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h1008, 32'h0, rd, er);
        check("bp_no_store", rd, 32'hDEAD_BEEF);

        // Reset on the commit edge of a store
        xact(0, 1'b1, 2'd2, 1'b0, 32'h1010, 32'h0, rd, er);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_op[0] = 2'd2;
        req_addr[0] = 32'h1010; req_wdata[0] = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_mid_rdata", rsp_rdata[0], 32'd0);
        check("rst_mid_err", 32'(rsp_err[0]), 32'd0);
        check("rst_mid_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        #1 check("rst_mid_ready_back", 32'(req_ready[0]), 32'd1);
        xact(0, 1'b0, 2'd2, 1'b0, 32'h1010, 32'h0, rd, er);
        check("rst_mid_no_write", rd, 32'h0);

        // Latency sweep: WAIT_CYCLES 0 and 7
        for (int k = 1; k < 3; k++) begin
            xact(k, 1'b1, 2'd2, 1'b0, 32'h1020, 32'hCAFE_F00D, rd, er);
            xact(k, 1'b0, 2'd2, 1'b0, 32'h1020, 32'h0, rd, er);
            check("sweep_word", rd, 32'hCAFE_F00D);
        end

        // Random traffic on all instances within an initialised 64-byte window
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 16; w++)
                xact(k, 1'b1, 2'd2, 1'b0, 32'h1000 + 32'(4 * w), $urandom, rd, er);
            for (int n = 0; n < 30; n++) begin
                int sel;
                logic [31:0] a;
                sel = $urandom_range(0, 9);
                if (sel == 0) a = 32'h2000 + 32'($urandom_range(0, 15));
                else if (sel == 1) a = 32'h0FF0 + 32'($urandom_range(0, 15));
                else a = 32'h1000 + 32'($urandom_range(0, 63));
                xact(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), a, $urandom, rd, er);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
